wb_port_arbiter: RTL

// - Shares the single register-file write port between the in-order pipeline WB stage and the

---
 rtl/wb_arb_pkg.sv | 11 +
 rtl/wb_port_arbiter_if.sv | 37 +++
 rtl/wb_fifo.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared widths and the buffered write-back entry type for the write-port arbiter.
package wb_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles the WB-stage, MDU, ID and register-file signals around the write-port arbiter.
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic                  pipe_we_i;
    logic [REG_ADDR_W-1:0] pipe_addr_i;
    logic [DATA_W-1:0]     pipe_data_i;
    logic                  mdu_valid_i;
    logic [REG_ADDR_W-1:0] mdu_addr_i;
    logic [DATA_W-1:0]     mdu_data_i;
    logic                  mdu_ready_o;
    logic                  issue_i;
    logic [REG_ADDR_W-1:0] issue_addr_i;
    logic [REG_ADDR_W-1:0] rs_addr_i;
    logic [REG_ADDR_W-1:0] rt_addr_i;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic                  stall_o;
    logic                  RegWrite_o;
    logic [REG_ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0]     RDdata_o;
    logic [NUM_REGS-1:0]   busy_o;
    logic                  err_o;

    modport slave (
        input  pipe_we_i, pipe_addr_i, pipe_data_i,
        input  mdu_valid_i, mdu_addr_i, mdu_data_i,
        input  issue_i, issue_addr_i, rs_addr_i, rt_addr_i, rd_addr_i,
        output mdu_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o, busy_o, err_o
    );

    modport master (
        output pipe_we_i, pipe_addr_i, pipe_data_i,
        output mdu_valid_i, mdu_addr_i, mdu_data_i,
        output issue_i, issue_addr_i, rs_addr_i, rt_addr_i, rd_addr_i,
        input  mdu_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o, busy_o, err_o
    );
endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of write-back entries; head visible the cycle after push.
// Pushes while full and pops while empty are ignored.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  wb_entry_t        push_dat_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_dat_i;
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between WB (priority) and buffered MDU results; 1-cycle registered write.
// MDU back-pressured via mdu_ready_o when the buffer is full; ID frozen by stall_o. WB_ARB_CHECK_EN builds the protocol checker.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input logic               clk_i,
    input logic               rst_n_i,
    wb_port_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = 5;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t            fifo_head, win;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop, win_vld, starve;
    logic [NUM_REGS-1:0]  busy_q, busy_nxt;
    logic [OUT_W-1:0]     out_q, out_nxt;
    logic [STV_W-1:0]     starve_q;
    logic                 reg_we_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0]    rd_data_q;

    assign push = bus.mdu_valid_i & ~fifo_full;
    assign bus.mdu_ready_o = (fifo_count < CNT_W'(FIFO_DEPTH));

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (push),
        .push_dat_i ('{addr: bus.mdu_addr_i, data: bus.mdu_data_i}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    always_comb begin
        win_vld  = bus.pipe_we_i | ~fifo_empty;
        pop      = ~bus.pipe_we_i & ~fifo_empty;
        win      = bus.pipe_we_i ? '{addr: bus.pipe_addr_i, data: bus.pipe_data_i} : fifo_head;

        // Clear before set so an issue to the register being retired keeps it busy.
        busy_nxt = busy_q;
        if (pop)         busy_nxt[fifo_head.addr]  = 1'b0;
        if (bus.issue_i) busy_nxt[bus.issue_addr_i] = 1'b1;
        busy_nxt[0] = 1'b0;

        out_nxt = out_q;
        if (bus.issue_i && !pop)                   out_nxt = out_q + OUT_W'(1);
        else if (!bus.issue_i && pop && out_q != '0) out_nxt = out_q - OUT_W'(1);
    end

    assign starve = (starve_q >= STV_W'(STARVE_LIMIT));

    assign bus.stall_o = busy_q[bus.rs_addr_i] | busy_q[bus.rt_addr_i] | busy_q[bus.rd_addr_i]
                       | (out_q == OUT_W'(MAX_OUTSTANDING)) | starve;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q    <= '0;
            out_q     <= '0;
            starve_q  <= '0;
            reg_we_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            busy_q   <= busy_nxt;
            out_q    <= out_nxt;
            reg_we_q <= win_vld & (win.addr != '0);
            if (win_vld) begin
                rd_addr_q <= win.addr;
                rd_data_q <= win.data;
            end
            if (pop)
                starve_q <= '0;
            else if (bus.pipe_we_i && !fifo_empty && !starve)
                starve_q <= starve_q + STV_W'(1);
        end
    end

    assign bus.RegWrite_o = reg_we_q;
    assign bus.RDaddr_o   = rd_addr_q;
    assign bus.RDdata_o   = rd_data_q;
    assign bus.busy_o     = busy_q;

`ifdef WB_ARB_CHECK_EN
    logic err_q, proto_err;

    // A result to r0 is legal: issues to r0 are counted but never marked busy.
    assign proto_err = (bus.pipe_we_i & busy_q[bus.pipe_addr_i])
                     | (bus.mdu_valid_i & (bus.mdu_addr_i != '0) & ~busy_q[bus.mdu_addr_i])
                     | (bus.issue_i & bus.stall_o)
                     | (pop & (out_q == '0));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
            $error("wb_port_arbiter: write-port protocol violation");
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule
